// File: rtl/sw_gate_pkg.sv
// Shared types and constants for the switch-to-LED display block.
// Holds the display-mode encoding, LED bit positions and small decode helpers.
package sw_gate_pkg;

    typedef enum logic [1:0] {
        MODE_GATE = 2'd0,
        MODE_RAW  = 2'd1,
        MODE_CNT  = 2'd2
    } mode_e;

    localparam int N_LED    = 4;
    localparam int LED_AND  = 0;
    localparam int LED_OR   = 1;
    localparam int LED_XOR  = 2;
    localparam int LED_NAND = 3;

    // Even-parity of up to 16 switch bits; narrower vectors are zero-extended by the caller.
    function automatic logic parity16(input logic [15:0] vec);
        return ^vec;
    endfunction

    function automatic logic [N_LED-1:0] gate_leds(input logic all_s, input logic any_s,
                                                   input logic par_s);
        logic [N_LED-1:0] leds_v;
        leds_v           = {N_LED{1'b0}};
        leds_v[LED_AND]  = all_s;
        leds_v[LED_OR]   = any_s;
        leds_v[LED_XOR]  = par_s;
        leds_v[LED_NAND] = ~all_s;
        return leds_v;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus optional per-bit debouncer for asynchronous inputs.
// Build option: SW_DEBOUNCE_EN enables the debounce counters; otherwise dout is the synchronised input.
module sw_debounce #(
    parameter int WIDTH      = 1,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
        $error("DEB_CYCLES must be at least 1");
    end

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;

    // Two-stage synchroniser into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_r <= {WIDTH{1'b0}};
            s2_r <= {WIDTH{1'b0}};
        end else begin
            s1_r <= din;
            s2_r <= s1_r;
        end
    end

`ifdef SW_DEBOUNCE_EN
    // A one-cycle debounce still needs a 1-bit counter so the vector is never zero-width.
    localparam int              CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] stable_r;
    logic [CNT_W-1:0] cnt_r [WIDTH];

    // Accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_r <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (cnt_r[i] == CNT_MAX) begin
                    stable_r[i] <= s2_r[i];
                    cnt_r[i]    <= {CNT_W{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    assign dout = stable_r;
`else
    assign dout = s2_r;
`endif

endmodule

// File: rtl/sw_gate_display.sv
// Switch-to-LED display: conditioned switches shown as gate results, raw bits or a change count.
// Build option: define SW_DEBOUNCE_EN to debounce switches and the mode button.
module sw_gate_display
    import sw_gate_pkg::*;
#(
    parameter int N_SW       = 2,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SW-1:0]  sw,
    input  logic             btn_mode,
    output logic [N_LED-1:0] led,
    output logic [1:0]       mode_o
);

    if (N_SW < 2 || N_SW > 16) begin : g_bad_n_sw
        $error("N_SW must be in 2..16");
    end

    logic [N_SW-1:0]  sw_db_s;
    logic             btn_db_s;
    logic [N_SW-1:0]  sw_prev_r;
    logic             btn_prev_r;
    logic             btn_rise_s;
    logic             sw_chg_s;
    mode_e            mode_r;
    mode_e            mode_nxt_s;
    logic [N_LED-1:0] chg_cnt_r;
    logic [N_LED-1:0] chg_cnt_nxt_s;
    logic [N_LED-1:0] led_r;
    logic [N_LED-1:0] led_nxt_s;
    logic [N_LED-1:0] sw_low_s;

    sw_debounce #(
        .WIDTH      (N_SW),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sw_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sw),
        .dout  (sw_db_s)
    );

    sw_debounce #(
        .WIDTH      (1),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn_mode),
        .dout  (btn_db_s)
    );

    if (N_SW >= N_LED) begin : g_sw_trunc
        assign sw_low_s = sw_db_s[N_LED-1:0];
    end else begin : g_sw_ext
        assign sw_low_s = {{(N_LED - N_SW){1'b0}}, sw_db_s};
    end

    // Mode advance, change counting and LED decode for the next edge.
    always_comb begin
        btn_rise_s    = btn_db_s & ~btn_prev_r;
        sw_chg_s      = (sw_db_s != sw_prev_r);
        mode_nxt_s    = mode_r;
        chg_cnt_nxt_s = chg_cnt_r;
        led_nxt_s     = {N_LED{1'b0}};

        if (btn_rise_s) begin
            case (mode_r)
                MODE_GATE: mode_nxt_s = MODE_RAW;
                MODE_RAW:  mode_nxt_s = MODE_CNT;
                MODE_CNT:  mode_nxt_s = MODE_GATE;
                default:   mode_nxt_s = MODE_GATE;
            endcase
        end else begin
            mode_nxt_s = mode_r;
        end

        if (sw_chg_s) begin
            chg_cnt_nxt_s = chg_cnt_r + 4'd1;
        end else begin
            chg_cnt_nxt_s = chg_cnt_r;
        end

        // The unreachable encoding 3 shows the gate view, same as mode 0.
        case (mode_r)
            MODE_GATE: led_nxt_s = gate_leds(&sw_db_s, |sw_db_s, parity16(16'(sw_db_s)));
            MODE_RAW:  led_nxt_s = sw_low_s;
            MODE_CNT:  led_nxt_s = chg_cnt_r;
            default:   led_nxt_s = gate_leds(&sw_db_s, |sw_db_s, parity16(16'(sw_db_s)));
        endcase
    end

    // Display state and registered LED drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_prev_r  <= {N_SW{1'b0}};
            btn_prev_r <= 1'b0;
            mode_r     <= MODE_GATE;
            chg_cnt_r  <= {N_LED{1'b0}};
            led_r      <= {N_LED{1'b0}};
        end else begin
            sw_prev_r  <= sw_db_s;
            btn_prev_r <= btn_db_s;
            mode_r     <= mode_nxt_s;
            chg_cnt_r  <= chg_cnt_nxt_s;
            led_r      <= led_nxt_s;
        end
    end

    assign led    = led_r;
    assign mode_o = mode_r;

endmodule
